svnet_pipeline_read_scheduler: RTL and testbench
================================================

// Module: svnet_pipeline_read_scheduler
// PURPOSE
// Round-robin scheduler sharing one fixed-latency pipeline between NUM_SOURCES FIFO sources.
// Grants at most one source read per cycle, gated by per-source used space and sink credits.
// Tracks each grant through a DELAY-deep tag line so the sink knows which source each output
// belongs to. Sits between the source FIFOs' used-space outputs and the shared pipeline input.
// PARAMETERS
// NUM_SOURCES  4   requesters, >=2
// DEPTH        16  source FIFO depth; used-space fields are $clog2(DEPTH)+1 bits (UW)
// DELAY        2   pipeline latency in cycles, >=1
// CREDITS      8   sink slots; credit counter is $clog2(CREDITS)+1 bits
// PORTS
// clk                 in   1               clock
// rst_n               in   1               asynchronous active-low reset
// enable              in   1               1 = schedule; 0 = stop granting and drain
// src_used_space      in   NUM_SOURCES*UW  packed per-source used space, source i at [i*UW +: UW]
// src_read            out  NUM_SOURCES     one-hot read grant (0 or 1 bit set)
// out_valid           out  1               a granted item leaves the pipeline this cycle
// out_sel             out  $clog2(NUM_SOURCES)  source index of the emerging item
// sink_credit_return  in   1               sink freed one slot
// credits             out  $clog2(CREDITS)+1    current credit count
// drained             out  1               IDLE and tag line empty
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; ptr_q=0; credits=CREDITS; tag line cleared; src_read=0;
//   out_valid=0; out_sel=0; drained=1; last_grant_q=0.
// - FSM: IDLE -enable=1-> RUN; RUN -enable=0-> DRAIN; DRAIN -tag line empty-> IDLE;
//   DRAIN -enable=1-> RUN (no empty wait). Grants issue only in RUN.
// - Eligibility: source i eligible iff src_used_space[i] > last_grant_q[i], where last_grant_q
//   is src_read registered (source used space updates one cycle after a read).
// - Grant: in RUN with credits>0, the first eligible source searching ptr_q, ptr_q+1, ... mod N
//   gets src_read[i]=1 combinationally the same cycle; ptr_q <= (i+1) mod N. No grant -> ptr holds.
// - Credits: -1 on grant, +1 on sink_credit_return; both same cycle -> unchanged. credits=0
//   blocks grants even if a return arrives that cycle (return takes effect next cycle).
//   Return while credits==CREDITS: counter saturates, assertion fires.
// - Tag line: DELAY registered stages of {valid,sel}; stage0 <= {|src_read, index}; out_valid/
//   out_sel = last stage, so exactly DELAY cycles from grant to out_valid. out_sel holds its
//   last value when out_valid=0. Tag line keeps shifting in all states.
// - drained = (state==IDLE) && no valid stage in tag line; registered.
// - Assertions: $onehot0(src_read); src_read[i] |-> src_used_space[i]!=0; credits<=CREDITS;
//   final: if rst_n, tag line empty at end of simulation.
// - Reset mid-operation: in-flight tags and outstanding credits are discarded; credits restart
//   at CREDITS; sink and sources are reset together.
// CONFIGURATION
// SVNET_PIPELINE_READ_SCHEDULER_STATS_EN: when defined, adds output stall_cycles [31:0], reset 0,
// +1 each RUN cycle with >=1 eligible source and credits==0, saturating at 2^32-1.
// When undefined the port and counter do not exist; all other behaviour identical.
// TESTING
// - Reset, enable=1, src0 used=3, others 0, CREDITS=8 -> src_read=0001 on cycles where
//   3>last_grant, 3 grants max as space falls; out_valid 2 cycles after each, out_sel=0.
// - All 4 sources used=5, no credit limit -> grants 0,1,2,3,0,1 in consecutive cycles.
// - CREDITS=2, no returns, sources full -> exactly 2 grants then src_read=0; one return ->
//   one grant the next cycle; simultaneous grant+return -> credits unchanged.
// - enable drops with 2 tags in flight -> no further grants, out_valid for 2 cycles,
//   drained=1 the cycle after the line empties; re-enable -> RUN, grants resume at ptr_q.
// - rst_n asserted with tags in flight -> out_valid=0, credits=8, drained=1 immediately.
// - With STATS_EN: credits=0 and src1 eligible for 10 RUN cycles -> stall_cycles=10.

Source files
------------

// File: rtl/svnet_pipeline_read_scheduler.sv
// -----------------------------------------------------------------------------
// svnet_pipeline_read_scheduler
//
// Round-robin scheduler that shares one fixed-latency pipeline between
// NUM_SOURCES FIFO sources. At most one source is read per cycle. A read needs
// the source to hold data not already claimed by last cycle's read, and needs
// a free sink credit. Each grant is tagged with its source index and carried
// down a DELAY-deep tag line, so the sink knows which source each pipeline
// output belongs to.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              1 = schedule, 0 = stop granting and drain
//   src_used_space      packed used space, source i at [i*UW +: UW]
//   src_read            one-hot read grant (combinational, same cycle)
//   out_valid, out_sel  tag line output: item emerging and its source index
//   sink_credit_return  sink freed one slot
//   credits             current credit count
//   drained             idle with an empty tag line
//   stall_cycles        (only with SVNET_PIPELINE_READ_SCHEDULER_STATS_EN)
//                       RUN cycles lost to credit starvation, saturating
//
// Optional feature macro: SVNET_PIPELINE_READ_SCHEDULER_STATS_EN
// -----------------------------------------------------------------------------
module svnet_pipeline_read_scheduler #(
    parameter int NUM_SOURCES = 4,
    parameter int DEPTH       = 16,
    parameter int DELAY       = 2,
    parameter int CREDITS     = 8,
    localparam int UW = $clog2(DEPTH) + 1,
    localparam int SW = $clog2(NUM_SOURCES),
    localparam int CW = $clog2(CREDITS) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUM_SOURCES*UW-1:0] src_used_space,
    output logic [NUM_SOURCES-1:0]    src_read,
    output logic                      out_valid,
    output logic [SW-1:0]             out_sel,
    input  logic                      sink_credit_return,
    output logic [CW-1:0]             credits,
    output logic                      drained
`ifdef SVNET_PIPELINE_READ_SCHEDULER_STATS_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [SW-1:0]                  r_ptr;
    logic [CW-1:0]                  r_credits;
    logic [NUM_SOURCES-1:0]         r_last_grant;
    logic [DELAY-1:0]               r_tag_vld;
    logic [DELAY-1:0][SW-1:0]       r_tag_sel;
    logic                           r_drained;

    logic [NUM_SOURCES-1:0]         w_elig;
    logic [NUM_SOURCES-1:0]         w_nz;
    logic                           w_found;
    logic [SW-1:0]                  w_idx;
    logic                           w_grant;
    logic                           w_tag_busy_nxt;

    // A source read last cycle has not yet shown up in its used space, so one
    // entry of it is already spoken for.
    always_comb begin
        w_elig = '0;
        w_nz   = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            w_elig[i] = src_used_space[i*UW +: UW] > {{(UW-1){1'b0}}, r_last_grant[i]};
            w_nz[i]   = src_used_space[i*UW +: UW] != '0;
        end
    end

    // First eligible source at or after the round-robin pointer.
    always_comb begin
        int j;
        j       = 0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            j = (int'(r_ptr) + k) % NUM_SOURCES;
            if (!w_found && w_elig[j]) begin
                w_found = 1'b1;
                w_idx   = SW'(j);
            end
        end
    end

    assign w_grant  = (r_state == RUN) && (r_credits != '0) && w_found;
    assign src_read = w_grant ? (NUM_SOURCES'(1) << w_idx) : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_nxt = RUN;
            RUN:     if (!enable) w_state_nxt = DRAIN;
            DRAIN:   if (enable) w_state_nxt = RUN;
                     else if (r_tag_vld == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Occupancy of the tag line after this edge: the new grant plus every
    // stage that is not falling off the end.
    always_comb begin
        w_tag_busy_nxt = w_grant;
        for (int s = 0; s < DELAY - 1; s++)
            w_tag_busy_nxt = w_tag_busy_nxt | r_tag_vld[s];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_credits    <= CW'(CREDITS);
            r_last_grant <= '0;
            r_drained    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= src_read;
            // Computed from next-state values so drained rises together with IDLE.
            r_drained    <= (w_state_nxt == IDLE) && !w_tag_busy_nxt;
            if (w_grant) begin
                if (w_idx == SW'(NUM_SOURCES - 1)) r_ptr <= '0;
                else                               r_ptr <= w_idx + SW'(1);
            end
            case ({w_grant, sink_credit_return})
                2'b10:   r_credits <= r_credits - CW'(1);
                2'b01:   if (r_credits != CW'(CREDITS)) r_credits <= r_credits + CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Tag line. Stage 0 keeps its old index when nothing is granted, so the
    // last stage presents the most recently emerged source while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            r_tag_sel <= '0;
        end else begin
            r_tag_vld[0] <= w_grant;
            if (w_grant) r_tag_sel[0] <= w_idx;
            for (int s = 1; s < DELAY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_sel[s] <= r_tag_sel[s-1];
            end
        end
    end

    assign out_valid = r_tag_vld[DELAY-1];
    assign out_sel   = r_tag_sel[DELAY-1];
    assign credits   = r_credits;
    assign drained   = r_drained;

`ifdef SVNET_PIPELINE_READ_SCHEDULER_STATS_EN
    logic [31:0] r_stall;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall <= '0;
        else if ((r_state == RUN) && (|w_elig) && (r_credits == '0) && (r_stall != '1))
            r_stall <= r_stall + 32'd1;
    end
    assign stall_cycles = r_stall;
`endif

`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(src_read));
    a_nonempty: assert property (@(posedge clk) disable iff (!rst_n) (src_read & ~w_nz) == '0);
    a_credit_max: assert property (@(posedge clk) disable iff (!rst_n) r_credits <= CW'(CREDITS));
    a_credit_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(sink_credit_return && !w_grant && (r_credits == CW'(CREDITS))));
    final begin
        if (rst_n) assert (r_tag_vld == '0);
    end
`endif

endmodule

// File: tb/tb_svnet_pipeline_read_scheduler.sv
module tb_svnet_pipeline_read_scheduler;
    localparam int N   = 4;
    localparam int UW  = 5;
    localparam int SW  = 2;
    localparam int CW  = 4;
    localparam int DLY = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            enable;
    logic            sink_credit_return;
    logic [N*UW-1:0] src_used_space;
    logic [UW-1:0]   used [N];
    logic [N-1:0]    src_read;
    logic            out_valid;
    logic [SW-1:0]   out_sel;
    logic [CW-1:0]   credits;
    logic            drained;
`ifdef SVNET_PIPELINE_READ_SCHEDULER_STATS_EN
    logic [31:0]     stall_cycles;
`endif

    always #5 clk = ~clk;

    always_comb begin
        src_used_space = '0;
        for (int i = 0; i < N; i++) src_used_space[i*UW +: UW] = used[i];
    end

    svnet_pipeline_read_scheduler dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .src_used_space     (src_used_space),
        .src_read           (src_read),
        .out_valid          (out_valid),
        .out_sel            (out_sel),
        .sink_credit_return (sink_credit_return),
        .credits            (credits),
        .drained            (drained)
`ifdef SVNET_PIPELINE_READ_SCHEDULER_STATS_EN
        ,
        .stall_cycles       (stall_cycles)
`endif
    );

    typedef struct {
        int sel;
        int due;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   fifo_mode = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock; in fifo mode a granted source's used space drops one cycle later.
    task automatic tick();
        logic [N-1:0] rd;
        rd = src_read;
        @(posedge clk);
        cyc++;
        #1;
        if (fifo_mode)
            for (int i = 0; i < N; i++)
                if (rd[i]) used[i] = used[i] - 5'd1;
        #1;
    endtask

    // Check the grant for this cycle and queue the tag it should produce.
    task automatic step(input logic [N-1:0] exp_rd);
        #1;
        chk("src_read", src_read, exp_rd);
        for (int i = 0; i < N; i++)
            if (exp_rd[i]) q.push_back('{sel: i, due: cyc + DLY});
        tick();
    endtask

    task automatic set_all(input logic [UW-1:0] v);
        for (int i = 0; i < N; i++) used[i] = v;
    endtask

    // Monitor: every emerging item must match the queue head in index and timing.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL out_valid: got 1 expected 0 (nothing in flight, cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_sel", out_sel, e.sel);
                    chk("out_cycle", cyc, e.due);
                end
            end else if (q.size() != 0 && q[0].due == cyc) begin
                chk("out_valid", out_valid, 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        sink_credit_return = 1'b0;
        set_all(5'd0);
        repeat (3) tick();
        chk("rst_src_read", src_read, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_credits", credits, 8);
        chk("rst_drained", drained, 1);
        rst_n = 1'b1;
        tick();

        // Single source with 3 entries; the source model lags reads by a cycle.
        enable = 1'b1;
        used[0] = 5'd3;
        fifo_mode = 1'b1;
        chk("idle_drained", drained, 1);
        step(4'b0000);
        step(4'b0001);
        step(4'b0001);
        step(4'b0000);
        step(4'b0001);
        step(4'b0000);
        step(4'b0000);
        chk("p1_credits", credits, 5);
        sink_credit_return = 1'b1;
        repeat (3) step(4'b0000);
        sink_credit_return = 1'b0;
        chk("p1_refill", credits, 8);

        // All sources busy; a return each grant cycle keeps credits level.
        set_all(5'd5);
        sink_credit_return = 1'b1;
        step(4'b0010);
        step(4'b0100);
        step(4'b1000);
        step(4'b0001);
        step(4'b0010);
        step(4'b0100);
        sink_credit_return = 1'b0;
        set_all(5'd0);
        fifo_mode = 1'b0;
        step(4'b0000);
        chk("p2_credits", credits, 8);

        // Credit exhaustion, single returns, grant+return in the same cycle.
        set_all(5'd16);
        step(4'b1000); step(4'b0001); step(4'b0010); step(4'b0100);
        step(4'b1000); step(4'b0001); step(4'b0010); step(4'b0100);
        chk("p3_empty", credits, 0);
        repeat (10) step(4'b0000);
`ifdef SVNET_PIPELINE_READ_SCHEDULER_STATS_EN
        chk("stall_cycles", stall_cycles, 10);
`endif
        sink_credit_return = 1'b1;
        step(4'b0000);
        sink_credit_return = 1'b0;
        step(4'b1000);
        sink_credit_return = 1'b1;
        step(4'b0000);
        step(4'b0001);
        sink_credit_return = 1'b0;
        chk("p3_grant_ret", credits, 1);
        step(4'b0010);
        chk("p3_last", credits, 0);
        set_all(5'd0);
        sink_credit_return = 1'b1;
        repeat (8) step(4'b0000);
        sink_credit_return = 1'b0;
        chk("p3_refill", credits, 8);

        // Drain with two tags in flight, then resume at the pointer.
        set_all(5'd16);
        step(4'b0100);
        enable = 1'b0;
        step(4'b1000);
        chk("drain_t2", drained, 0);
        step(4'b0000);
        chk("drain_t3", drained, 0);
        step(4'b0000);
        chk("drain_t4", drained, 0);
        step(4'b0000);
        chk("drain_done", drained, 1);
        chk("drain_out_valid", out_valid, 0);
        chk("drain_sel_hold", out_sel, 3);
        enable = 1'b1;
        step(4'b0000);
        chk("resume_drained", drained, 0);
        step(4'b0001);
        chk("resume_credits", credits, 5);
        step(4'b0010);

        // Reset with tags in flight discards them.
        rst_n = 1'b0;
        q.delete();
        enable = 1'b0;
        set_all(5'd0);
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_credits", credits, 8);
        chk("mid_rst_drained", drained, 1);
        chk("mid_rst_src_read", src_read, 0);
        tick();
        rst_n = 1'b1;
        repeat (3) step(4'b0000);
        chk("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
